digit_scan_driver: RTL and testbench

DIGIT_SCAN_DRIVER -- requirements
Module: digit_scan_driver

---
 rtl/digit_scan_driver.sv | 135 +++++++++++++
 tb/tb_digit_scan_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_driver.sv
// Two-digit multiplexed 7-segment scanner with frame-synchronous shadows and timeout blink; DIGIT_SCAN_LAMP_TEST_EN adds Lamp_Test.
// Outputs are registered and computed from next-state values, so there is no stale cycle; no backpressure, Enable=0 freezes the scan.
module digit_scan_driver #(
    parameter logic [15:0] SCAN_DIV     = 16'd10_000,
    parameter logic [7:0]  BLINK_FRAMES = 8'd50
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Sec1,
    input  logic [3:0] Sec0,
    input  logic       Time_Out,
    input  logic       Enable,
`ifdef DIGIT_SCAN_LAMP_TEST_EN
    input  logic       Lamp_Test,
`endif
    output logic [6:0] Segments,
    output logic       Digit_Sel
);

    logic [15:0] r_presc;
    logic        r_digit_sel;
    logic [3:0]  r_sh_tens;
    logic [3:0]  r_sh_ones;
    logic [7:0]  r_frame_cnt;
    logic        r_blink_on;
    logic [6:0]  r_segments;

    logic        w_tick;
    logic        w_frame;
    logic        w_lamp;
    logic [15:0] w_presc_nxt;
    logic        w_sel_nxt;
    logic [3:0]  w_tens_nxt;
    logic [3:0]  w_ones_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_blink_nxt;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic [6:0]  w_seg_nxt;

`ifdef DIGIT_SCAN_LAMP_TEST_EN
    assign w_lamp = Lamp_Test;
`else
    assign w_lamp = 1'b0;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign w_tick  = Enable && (r_presc == SCAN_DIV - 16'd1);
    // A frame starts when the tens slot ends and the ones slot begins.
    assign w_frame = w_tick && r_digit_sel;

    always_comb begin
        w_presc_nxt = r_presc;
        w_sel_nxt   = r_digit_sel;
        w_tens_nxt  = r_sh_tens;
        w_ones_nxt  = r_sh_ones;
        w_cnt_nxt   = r_frame_cnt;
        w_blink_nxt = r_blink_on;
        if (Enable) begin
            w_presc_nxt = w_tick ? 16'd0 : r_presc + 16'd1;
            if (w_tick) begin
                w_sel_nxt = ~r_digit_sel;
            end
            if (w_frame) begin
                w_tens_nxt = Sec1;
                w_ones_nxt = Sec0;
            end
            if (!Time_Out) begin
                w_cnt_nxt   = 8'd0;
                w_blink_nxt = 1'b1;
            end else if (w_frame) begin
                if (r_frame_cnt == BLINK_FRAMES - 8'd1) begin
                    w_cnt_nxt   = 8'd0;
                    w_blink_nxt = ~r_blink_on;
                end else begin
                    w_cnt_nxt = r_frame_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_digit   = w_sel_nxt ? w_tens_nxt : w_ones_nxt;
        w_blank   = w_sel_nxt && (w_tens_nxt == 4'd0);
        w_seg_nxt = 7'h00;
        if (Enable) begin
            if (w_lamp) begin
                w_seg_nxt = 7'h7F;
            end else if (w_blink_nxt && !w_blank) begin
                w_seg_nxt = seg_decode(w_digit);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_presc     <= 16'd0;
            r_digit_sel <= 1'b0;
            r_sh_tens   <= 4'd0;
            r_sh_ones   <= 4'd0;
            r_frame_cnt <= 8'd0;
            r_blink_on  <= 1'b1;
            r_segments  <= 7'h00;
        end else begin
            r_presc     <= w_presc_nxt;
            r_digit_sel <= w_sel_nxt;
            r_sh_tens   <= w_tens_nxt;
            r_sh_ones   <= w_ones_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_blink_on  <= w_blink_nxt;
            r_segments  <= w_seg_nxt;
        end
    end

    assign Segments  = r_segments;
    assign Digit_Sel = r_digit_sel;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2; edge N means the Nth clock edge after reset release.
module tb_digit_scan_driver;

    logic       Clock;
    logic       Reset;
    logic [3:0] Sec1;
    logic [3:0] Sec0;
    logic       Time_Out;
    logic       Enable;
    logic       Lamp_Test;
    logic [6:0] Segments;
    logic       Digit_Sel;

    int n_checks;
    int n_pass;

    digit_scan_driver #(
        .SCAN_DIV     (16'd4),
        .BLINK_FRAMES (8'd2)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Sec1      (Sec1),
        .Sec0      (Sec0),
        .Time_Out  (Time_Out),
        .Enable    (Enable),
`ifdef DIGIT_SCAN_LAMP_TEST_EN
        .Lamp_Test (Lamp_Test),
`endif
        .Segments  (Segments),
        .Digit_Sel (Digit_Sel)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] exp_seg, input logic exp_sel);
        n_checks++;
        if (Segments !== exp_seg || Digit_Sel !== exp_sel)
            $display("FAIL %s: got Segments=%h Digit_Sel=%b, expected Segments=%h Digit_Sel=%b",
                     name, Segments, Digit_Sel, exp_seg, exp_sel);
        else
            n_pass++;
    endtask

    // Leaves the bench at edge 0: reset sampled on one edge, then released.
    task automatic do_reset();
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Enable = 1'b1; Time_Out = 1'b1; Sec1 = 4'd8; Sec0 = 4'd8;
        step(2);
        chk("reset_held", 7'h00, 1'b0);
        Enable = 1'b0; Time_Out = 1'b0;
        step(1);
        chk("reset_overrides_enable", 7'h00, 1'b0);
        Enable = 1'b1; Sec1 = 4'd4; Sec0 = 4'd2;
        Reset = 1'b0;
        step(1);
        chk("first_after_reset", 7'h3F, 1'b0);
    endtask

    task automatic test_scan();
        Sec1 = 4'd4; Sec0 = 4'd2; Time_Out = 1'b0; Enable = 1'b1;
        do_reset();
        step(3);
        chk("edge3_before_tick", 7'h3F, 1'b0);
        step(1);
        chk("edge4_tens_blank", 7'h00, 1'b1);
        step(4);
        chk("edge8_frame_ones", 7'h5B, 1'b0);
        step(4);
        chk("edge12_tens", 7'h66, 1'b1);
    endtask

    task automatic test_mid_frame();
        Sec1 = 4'd4; Sec0 = 4'd2; Time_Out = 1'b0; Enable = 1'b1;
        do_reset();
        step(12);
        Sec0 = 4'd9;
        step(2);
        chk("tens_unchanged_mid", 7'h66, 1'b1);
        step(2);
        chk("new_ones_at_frame", 7'h6F, 1'b0);
        Sec0 = 4'd3;
        step(3);
        chk("ones_change_held", 7'h6F, 1'b0);
        step(5);
        chk("ones_change_next_frame", 7'h4F, 1'b0);
    endtask

    task automatic test_decode();
        Sec1 = 4'd0; Sec0 = 4'd7; Time_Out = 1'b0; Enable = 1'b1;
        do_reset();
        step(8);
        chk("ones_7", 7'h07, 1'b0);
        step(4);
        chk("tens_zero_blank", 7'h00, 1'b1);
        Sec1 = 4'd10; Sec0 = 4'd12;
        step(4);
        chk("ones_dash", 7'h40, 1'b0);
        step(4);
        chk("tens_dash", 7'h40, 1'b1);
    endtask

    task automatic test_blink();
        Sec1 = 4'd4; Sec0 = 4'd2; Time_Out = 1'b1; Enable = 1'b1;
        do_reset();
        step(15);
        chk("blink_on_first", 7'h66, 1'b1);
        step(1);
        chk("blink_off_start", 7'h00, 1'b0);
        step(15);
        chk("blink_off_end", 7'h00, 1'b1);
        step(1);
        chk("blink_on_again", 7'h5B, 1'b0);
        step(15);
        chk("blink_on_end", 7'h66, 1'b1);
        step(1);
        chk("blink_off_second", 7'h00, 1'b0);
        step(2);
        Time_Out = 1'b0;
        step(1);
        chk("timeout_clear_shows", 7'h5B, 1'b0);
    endtask

    task automatic test_timeout_at_tick();
        Sec1 = 4'd4; Sec0 = 4'd2; Time_Out = 1'b0; Enable = 1'b1;
        do_reset();
        step(7);
        Time_Out = 1'b1;
        step(1);
        chk("timeout_with_frame", 7'h5B, 1'b0);
        step(7);
        chk("timeout_tick_on", 7'h66, 1'b1);
        step(1);
        chk("timeout_tick_off", 7'h00, 1'b0);
    endtask

    task automatic test_enable();
        Sec1 = 4'd4; Sec0 = 4'd2; Time_Out = 1'b0; Enable = 1'b1;
        do_reset();
        step(9);
        Enable = 1'b0;
        step(1);
        chk("disable_blank", 7'h00, 1'b0);
        Time_Out = 1'b1;
        step(9);
        chk("disable_frozen", 7'h00, 1'b0);
        Time_Out = 1'b0;
        Enable = 1'b1;
        step(2);
        chk("resume_slot", 7'h5B, 1'b0);
        step(1);
        chk("resume_tick", 7'h66, 1'b1);
    endtask

    task automatic test_reset_mid_blink();
        Sec1 = 4'd4; Sec0 = 4'd2; Time_Out = 1'b1; Enable = 1'b1;
        do_reset();
        step(20);
        chk("pre_reset_off", 7'h00, 1'b1);
        Reset = 1'b1;
        step(1);
        chk("reset_mid_blink", 7'h00, 1'b0);
        Reset = 1'b0;
        step(1);
        chk("after_reset_phase_on", 7'h3F, 1'b0);
        step(7);
        chk("after_reset_frame", 7'h5B, 1'b0);
        step(8);
        chk("after_reset_wrap", 7'h00, 1'b0);
    endtask

`ifdef DIGIT_SCAN_LAMP_TEST_EN
    task automatic test_lamp();
        Sec1 = 4'd0; Sec0 = 4'd5; Time_Out = 1'b1; Enable = 1'b1; Lamp_Test = 1'b1;
        do_reset();
        step(4);
        chk("lamp_tens_zero", 7'h7F, 1'b1);
        step(12);
        chk("lamp_blink_off_ones", 7'h7F, 1'b0);
        step(4);
        chk("lamp_blink_off_tens", 7'h7F, 1'b1);
        Enable = 1'b0;
        step(1);
        chk("lamp_disabled", 7'h00, 1'b1);
        Enable = 1'b1;
        Reset = 1'b1;
        step(1);
        chk("lamp_reset", 7'h00, 1'b0);
        Reset = 1'b0;
        Lamp_Test = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        Reset = 1'b1; Sec1 = 4'd0; Sec0 = 4'd0;
        Time_Out = 1'b0; Enable = 1'b1; Lamp_Test = 1'b0;
        test_reset();
        test_scan();
        test_mid_frame();
        test_decode();
        test_blink();
        test_timeout_at_tick();
        test_enable();
        test_reset_mid_blink();
`ifdef DIGIT_SCAN_LAMP_TEST_EN
        test_lamp();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
